rvv_group_sequencer: RTL and testbench

// - Parametrised LMUL micro-op sequencer between vector decode and vRegFile/vALU.
// - Accepts one vector op (vs1, vs2, vd, SEW, LMUL, vl) per valid/ready handshake and expands it

---
 rtl/rvv_group_sequencer_if.sv | 50 +++++
 rtl/rvv_group_sequencer.sv | 120 ++++++++++++
 tb/tb_rvv_group_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rvv_group_sequencer_if.sv
// rtl/rvv_group_sequencer_if.sv - op and micro-op handshake interfaces for rvv_group_sequencer
// rvv_op_if carries decoded vector ops plus the reject pulse; rvv_uop_if carries register-level micro-ops.
interface rvv_op_if #(
  parameter int RW  = 5,
  parameter int VLW = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [RW-1:0]  in_vs1;
  logic [RW-1:0]  in_vs2;
  logic [RW-1:0]  in_vd;
  logic [2:0]     in_sew;
  logic [2:0]     in_lmul;
  logic [VLW-1:0] in_vl;
  logic           illegal;

  modport master (
    output in_valid, in_vs1, in_vs2, in_vd, in_sew, in_lmul, in_vl,
    input  in_ready, illegal
  );
  modport slave (
    input  in_valid, in_vs1, in_vs2, in_vd, in_sew, in_lmul, in_vl,
    output in_ready, illegal
  );
endinterface

interface rvv_uop_if #(
  parameter int RW   = 5,
  parameter int VLW  = 8,
  parameter int VLEN = 64
);
  logic              uop_valid;
  logic              uop_ready;
  logic [RW-1:0]     uop_raA;
  logic [RW-1:0]     uop_raB;
  logic [RW-1:0]     uop_wa;
  logic [2:0]        uop_idx;
  logic              uop_last;
  logic [VLW-1:0]    uop_elems;
  logic [VLEN/8-1:0] uop_byte_en;

  modport master (
    output uop_valid, uop_raA, uop_raB, uop_wa, uop_idx, uop_last, uop_elems, uop_byte_en,
    input  uop_ready
  );
  modport slave (
    input  uop_valid, uop_raA, uop_raB, uop_wa, uop_idx, uop_last, uop_elems, uop_byte_en,
    output uop_ready
  );
endinterface

// File: rtl/rvv_group_sequencer.sv
// rtl/rvv_group_sequencer.sv - expands one vector op into LMUL register-level micro-ops with tail masks
// Optional macro RVV_SKIP_TAIL_UOPS_EN: suppress micro-ops whose element count is zero.
module rvv_group_sequencer #(
  parameter int VLEN = 64,
  parameter int NREG = 32,
  parameter int VLW  = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic   clk,
  input  logic   rst,
  rvv_op_if.slave  op,
  rvv_uop_if.master uop
);
  localparam int BYTES = VLEN / 8;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]     state;
  logic [RW-1:0]  vs1_q, vs2_q, vd_q;
  logic [1:0]     sew_q;
  logic [2:0]     gm1_q;
  logic [2:0]     idx_q;
  logic [VLW-1:0] rem_q;
  logic           illegal_q;

  logic           busy;
  logic [3:0]     g_in;
  logic [RW-1:0]  align_mask;
  logic           legal;
  int             epr_in;
  int             epr;
  int             bytes_c;
  logic [VLW-1:0] elems_c;
  logic           last_c;

  // Group size: integral LMUL gives 1<<lmul registers, fractional LMUL uses a single register.
  always_comb begin
    g_in       = op.in_lmul[2] ? 4'd1 : (4'd1 << op.in_lmul[1:0]);
    align_mask = RW'(g_in - 4'd1);
    epr_in     = VLEN >> (3 + int'(op.in_sew));
    legal      = !op.in_sew[2] && (op.in_lmul != 3'd4)
                 && ((op.in_vs1 & align_mask) == '0)
                 && ((op.in_vs2 & align_mask) == '0)
                 && ((op.in_vd  & align_mask) == '0)
                 && (int'(op.in_vl) <= int'(g_in) * epr_in);
  end

  // rem_q counts the elements not yet covered by earlier micro-ops of the group.
  always_comb begin
    busy    = (state == ISSUE);
    epr     = VLEN >> (3 + int'(sew_q));
    elems_c = (int'(rem_q) > epr) ? VLW'(epr) : rem_q;
    bytes_c = int'(elems_c) << sew_q;
`ifdef RVV_SKIP_TAIL_UOPS_EN
    last_c  = (idx_q == gm1_q) || (int'(rem_q) <= epr);
`else
    last_c  = (idx_q == gm1_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      sew_q     <= '0;
      gm1_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (op.in_valid) begin
            if (legal) begin
              state <= ISSUE;
              vs1_q <= op.in_vs1;
              vs2_q <= op.in_vs2;
              vd_q  <= op.in_vd;
              sew_q <= op.in_sew[1:0];
              gm1_q <= 3'(g_in - 4'd1);
              idx_q <= '0;
              rem_q <= op.in_vl;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        default: begin
          if (uop.uop_ready) begin
            if (last_c) begin
              state <= IDLE;
            end else begin
              idx_q <= idx_q + 3'd1;
              rem_q <= rem_q - elems_c;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    op.in_ready     = !busy;
    op.illegal      = illegal_q;
    uop.uop_valid   = busy;
    uop.uop_raA     = busy ? vs1_q + RW'(idx_q) : '0;
    uop.uop_raB     = busy ? vs2_q + RW'(idx_q) : '0;
    uop.uop_wa      = busy ? vd_q  + RW'(idx_q) : '0;
    uop.uop_idx     = busy ? idx_q : '0;
    uop.uop_last    = busy && last_c;
    uop.uop_elems   = busy ? elems_c : '0;
    uop.uop_byte_en = '0;
    for (int i = 0; i < BYTES; i++) begin
      uop.uop_byte_en[i] = busy && (i < bytes_c);
    end
  end
endmodule

// File: tb/tb_rvv_group_sequencer.sv
// tb/tb_rvv_group_sequencer.sv - scoreboard bench for rvv_group_sequencer at VLEN=64, NREG=32, VLW=8
module tb_rvv_group_sequencer;
  localparam int VLEN = 64;
  localparam int NREG = 32;
  localparam int VLW  = 8;
  localparam int RW   = 5;

  typedef struct packed {
    logic [RW-1:0]  ra;
    logic [RW-1:0]  rb;
    logic [RW-1:0]  wa;
    logic [2:0]     idx;
    logic           last;
    logic [VLW-1:0] elems;
    logic [7:0]     be;
  } uop_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ill_cnt = 0;
  uop_t sb[$];

  rvv_op_if  #(.RW(RW), .VLW(VLW))              opi ();
  rvv_uop_if #(.RW(RW), .VLW(VLW), .VLEN(VLEN)) ui ();

  rvv_group_sequencer #(.VLEN(VLEN), .NREG(NREG), .VLW(VLW)) dut (
    .clk(clk),
    .rst(rst),
    .op (opi.slave),
    .uop(ui.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input int ra, input int rb, input int wa, input int idx,
                               input int last, input int elems, input int be);
    uop_t u;
    u.ra = RW'(ra); u.rb = RW'(rb); u.wa = RW'(wa); u.idx = 3'(idx);
    u.last = 1'(last); u.elems = VLW'(elems); u.be = 8'(be);
    sb.push_back(u);
  endfunction

  // Monitor: every presented micro-op must match the queue head; it is popped once accepted.
  initial begin
    uop_t act;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ui.uop_valid) begin
          act = {ui.uop_raA, ui.uop_raB, ui.uop_wa, ui.uop_idx, ui.uop_last, ui.uop_elems, ui.uop_byte_en};
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL uop_unexpected: got %0h expected none", act);
          end else begin
            if (act !== sb[0]) begin
              bad++;
              $display("FAIL uop: got %0h expected %0h", act, sb[0]);
            end
            if (ui.uop_ready) void'(sb.pop_front());
          end
        end
        if (opi.illegal) begin
          total++;
          if (ill_cnt == 0) begin
            bad++;
            $display("FAIL illegal_unexpected: got 1 expected 0");
          end else begin
            ill_cnt--;
          end
        end
      end
    end
  end

  task automatic issue(input int vs1, input int vs2, input int vd, input int sew,
                       input int lmul, input int vl, input bit ok);
    int n = 0;
    while (!opi.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(opi.in_ready), 32'd1);
    opi.in_vs1 = RW'(vs1); opi.in_vs2 = RW'(vs2); opi.in_vd = RW'(vd);
    opi.in_sew = 3'(sew); opi.in_lmul = 3'(lmul); opi.in_vl = VLW'(vl);
    opi.in_valid = 1'b1;
    if (!ok) ill_cnt++;
    @(posedge clk); #1;
    opi.in_valid = 1'b0;
    if (ok) begin
      chk("first_uop_valid", 32'(ui.uop_valid), 32'd1);
      chk("in_ready_busy", 32'(opi.in_ready), 32'd0);
    end else begin
      chk("illegal_pulse", 32'(opi.illegal), 32'd1);
      chk("illegal_no_uop", 32'(ui.uop_valid), 32'd0);
      chk("illegal_ready", 32'(opi.in_ready), 32'd1);
      @(posedge clk); #1;
      chk("illegal_one_cycle", 32'(opi.illegal), 32'd0);
      chk("illegal_no_uop2", 32'(ui.uop_valid), 32'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (sb.size() != 0 && n < 100);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("idle_ready", 32'(opi.in_ready), 32'd1);
    chk("idle_no_uop", 32'(ui.uop_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    opi.in_valid = 1'b0; opi.in_vs1 = '0; opi.in_vs2 = '0; opi.in_vd = '0;
    opi.in_sew = '0; opi.in_lmul = '0; opi.in_vl = '0;
    ui.uop_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(opi.in_ready), 32'd1);
    chk("rst_uop_valid", 32'(ui.uop_valid), 32'd0);
    chk("rst_uop_last", 32'(ui.uop_last), 32'd0);
    chk("rst_illegal", 32'(opi.illegal), 32'd0);
    chk("rst_elems", 32'(ui.uop_elems), 32'd0);
    chk("rst_byte_en", 32'(ui.uop_byte_en), 32'd0);

    // full group, vl exactly at the limit
    push(8, 16, 24, 0, 0, 2, 8'hFF); push(9, 17, 25, 1, 0, 2, 8'hFF);
    push(10, 18, 26, 2, 0, 2, 8'hFF); push(11, 19, 27, 3, 1, 2, 8'hFF);
    issue(8, 16, 24, 2, 2, 8, 1);
    drain();

    // tail: vl=3 covers one and a half registers
`ifdef RVV_SKIP_TAIL_UOPS_EN
    push(8, 16, 24, 0, 0, 2, 8'hFF); push(9, 17, 25, 1, 1, 1, 8'h0F);
`else
    push(8, 16, 24, 0, 0, 2, 8'hFF); push(9, 17, 25, 1, 0, 1, 8'h0F);
    push(10, 18, 26, 2, 0, 0, 8'h00); push(11, 19, 27, 3, 1, 0, 8'h00);
`endif
    issue(8, 16, 24, 2, 2, 3, 1);
    drain();

    // stall on idx 1 for three cycles
    push(0, 4, 12, 0, 0, 2, 8'hFF); push(1, 5, 13, 1, 0, 2, 8'hFF);
    push(2, 6, 14, 2, 0, 2, 8'hFF); push(3, 7, 15, 3, 1, 2, 8'hFF);
    issue(0, 4, 12, 2, 2, 8, 1);
    @(posedge clk); #1;
    ui.uop_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ui.uop_ready = 1'b1;
    drain();

    // illegal ops: misaligned vd, bad SEW, LMUL code 4, vl over group capacity
    issue(0, 2, 3, 0, 1, 1, 0);
    issue(0, 0, 0, 5, 0, 1, 0);
    issue(0, 0, 0, 0, 4, 1, 0);
    issue(0, 0, 0, 2, 0, 3, 0);

    // fractional LMUL, SEW=8, vl=5
    push(1, 2, 3, 0, 1, 5, 8'h1F);
    issue(1, 2, 3, 0, 7, 5, 1);
    drain();

    // vl=0
`ifdef RVV_SKIP_TAIL_UOPS_EN
    push(2, 4, 6, 0, 1, 0, 8'h00);
`else
    push(2, 4, 6, 0, 0, 0, 8'h00); push(3, 5, 7, 1, 1, 0, 8'h00);
`endif
    issue(2, 4, 6, 0, 1, 0, 1);
    drain();

    // reset while idx 2 of 4 is pending
    push(8, 16, 24, 0, 0, 2, 8'hFF); push(9, 17, 25, 1, 0, 2, 8'hFF);
    issue(8, 16, 24, 2, 2, 8, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ui.uop_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ui.uop_ready = 1'b1;
    chk("rst_mid_uop_valid", 32'(ui.uop_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(opi.in_ready), 32'd1);
    chk("rst_mid_sb", 32'(sb.size()), 32'd0);

    // SEW=64, LMUL=2 after the abandoned op
    push(2, 4, 6, 0, 0, 1, 8'hFF); push(3, 5, 7, 1, 1, 1, 8'hFF);
    issue(2, 4, 6, 3, 1, 2, 1);
    drain();

    repeat (3) @(posedge clk);
    chk("illegal_all_seen", 32'(ill_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
